// File: rtl/fm_parity_check.sv
// fm_parity_check
//   Parity checker for the fast-memory (AC block). On each FM write it stores
//   one odd-parity bit per half-word, regenerated from the EDP slice XOR
//   outputs. On each checked FM read it compares the stored bit against the
//   freshly regenerated parity and latches the first error with its address.
//
//   Geometry: 8 blocks x 16 ACs = 128 entries, two halves (left/right) each.
//
// Ports
//   clk_apr_h                  in   clock, rising edge
//   apr_reset_l                in   asynchronous active-low reset
//   apr_fm_block_{1,2,4}_h     in   FM block number
//   apr_fm_adr_{1,2,4,10}_h    in   AC number
//   con_fm_write_00to17_l      in   left-half write strobe (active low)
//   con_fm_write_18to35_l      in   right-half write strobe (active low)
//   con_fm_check_en_h          in   check request for the current address
//   edp_fm_parity_*_h          in   six slice XOR outputs
//   apr_fm_par_clr_h           in   clear the error latch
//   apr_fm_inject_h            in   store inverted parity on writes
//   apr_fm_par_err_h           out  error latch
//   apr_fm_par_overrun_h       out  further error while latched
//   apr_fm_err_adr_h[6:0]      out  captured {block, adr}
//   apr_fm_err_half_h[1:0]     out  captured halves, [1]=left [0]=right
//
// Configuration macro
//   FM_PARITY_INJECT_EN  when defined, apr_fm_inject_h inverts the stored
//                        parity; otherwise the input is ignored.

module fm_parity_check (
  input  logic       clk_apr_h,
  input  logic       apr_reset_l,
  input  logic       apr_fm_block_1_h,
  input  logic       apr_fm_block_2_h,
  input  logic       apr_fm_block_4_h,
  input  logic       apr_fm_adr_1_h,
  input  logic       apr_fm_adr_2_h,
  input  logic       apr_fm_adr_4_h,
  input  logic       apr_fm_adr_10_h,
  input  logic       con_fm_write_00to17_l,
  input  logic       con_fm_write_18to35_l,
  input  logic       con_fm_check_en_h,
  input  logic       edp_fm_parity_00to05_h,
  input  logic       edp_fm_parity_06to11_h,
  input  logic       edp_fm_parity_12to17_h,
  input  logic       edp_fm_parity_18to23_h,
  input  logic       edp_fm_parity_24to29_h,
  input  logic       edp_fm_parity_30to35_h,
  input  logic       apr_fm_par_clr_h,
  input  logic       apr_fm_inject_h,
  output logic       apr_fm_par_err_h,
  output logic       apr_fm_par_overrun_h,
  output logic [6:0] apr_fm_err_adr_h,
  output logic [1:0] apr_fm_err_half_h
);

  typedef enum logic {IDLE = 1'b0, LATCHED = 1'b1} state_t;

  function automatic logic odd_par(input logic [2:0] slices);
    return ~(^slices);
  endfunction

  logic [6:0] idx;
  logic       pl, pr;
  logic       wr_l, wr_r;
  logic       inj;

  assign idx  = {apr_fm_block_4_h, apr_fm_block_2_h, apr_fm_block_1_h,
                 apr_fm_adr_10_h, apr_fm_adr_4_h, apr_fm_adr_2_h, apr_fm_adr_1_h};
  assign pl   = odd_par({edp_fm_parity_12to17_h, edp_fm_parity_06to11_h,
                         edp_fm_parity_00to05_h});
  assign pr   = odd_par({edp_fm_parity_30to35_h, edp_fm_parity_24to29_h,
                         edp_fm_parity_18to23_h});
  assign wr_l = ~con_fm_write_00to17_l;
  assign wr_r = ~con_fm_write_18to35_l;

`ifdef FM_PARITY_INJECT_EN
  assign inj = apr_fm_inject_h;
`else
  logic unused_inj;
  assign inj        = 1'b0;
  assign unused_inj = apr_fm_inject_h;
`endif

  // Parity store: valid bits are reset, parity bits are plain data.
  logic [127:0] val_l_q, val_r_q;
  logic [127:0] par_l_q, par_r_q;

  always_ff @(posedge clk_apr_h or negedge apr_reset_l) begin
    if (!apr_reset_l) begin
      val_l_q <= '0;
      val_r_q <= '0;
    end else begin
      if (wr_l) val_l_q[idx] <= 1'b1;
      if (wr_r) val_r_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_apr_h) begin
    if (wr_l) par_l_q[idx] <= pl ^ inj;
    if (wr_r) par_r_q[idx] <= pr ^ inj;
  end

  // ---- stage p1: sampled check (store read before this edge's write) ----
  logic       vld_p1;
  logic [6:0] idx_p1;
  logic       chk_l_p1, chk_r_p1;
  logic       spar_l_p1, spar_r_p1;
  logic       rpar_l_p1, rpar_r_p1;

  always_ff @(posedge clk_apr_h or negedge apr_reset_l) begin
    if (!apr_reset_l) vld_p1 <= 1'b0;
    else              vld_p1 <= con_fm_check_en_h;
  end

  // A half written at the sampling edge is excluded: the write wins.
  always_ff @(posedge clk_apr_h) begin
    idx_p1    <= idx;
    chk_l_p1  <= val_l_q[idx] & ~wr_l;
    chk_r_p1  <= val_r_q[idx] & ~wr_r;
    spar_l_p1 <= par_l_q[idx];
    spar_r_p1 <= par_r_q[idx];
    rpar_l_p1 <= pl;
    rpar_r_p1 <= pr;
  end

  logic [1:0] mis;
  assign mis = {vld_p1 & chk_l_p1 & (spar_l_p1 ^ rpar_l_p1),
                vld_p1 & chk_r_p1 & (spar_r_p1 ^ rpar_r_p1)};

  // ---- stage p2: error latch ----
  state_t     state_q;
  logic       err_q, ovr_q;
  logic [6:0] adr_q;
  logic [1:0] half_q;

  // A mismatch coinciding with clear captures fresh, as if the latch was idle.
  always_ff @(posedge clk_apr_h or negedge apr_reset_l) begin
    if (!apr_reset_l) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      adr_q   <= '0;
      half_q  <= '0;
    end else if (|mis) begin
      if (state_q == IDLE || apr_fm_par_clr_h) begin
        state_q <= LATCHED;
        err_q   <= 1'b1;
        ovr_q   <= 1'b0;
        adr_q   <= idx_p1;
        half_q  <= mis;
      end else begin
        ovr_q   <= 1'b1;
      end
    end else if (apr_fm_par_clr_h) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      adr_q   <= '0;
      half_q  <= '0;
    end
  end

  assign apr_fm_par_err_h     = err_q;
  assign apr_fm_par_overrun_h = ovr_q;
  assign apr_fm_err_adr_h     = adr_q;
  assign apr_fm_err_half_h    = half_q;

endmodule

// File: tb/tb_fm_parity_check.sv
module tb_fm_parity_check;

`ifdef FM_PARITY_INJECT_EN
  localparam bit INJ_EN = 1'b1;
`else
  localparam bit INJ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] ix = '0;
  logic       wl_n = 1'b1, wr_n = 1'b1, ck = 1'b0, clr = 1'b0, inj = 1'b0;
  logic [5:0] p = '0;
  logic       err, ovr;
  logic [6:0] eadr;
  logic [1:0] ehalf;

  always #5 clk = ~clk;

  fm_parity_check dut (
    .clk_apr_h             (clk),
    .apr_reset_l           (rst_n),
    .apr_fm_block_1_h      (ix[4]),
    .apr_fm_block_2_h      (ix[5]),
    .apr_fm_block_4_h      (ix[6]),
    .apr_fm_adr_1_h        (ix[0]),
    .apr_fm_adr_2_h        (ix[1]),
    .apr_fm_adr_4_h        (ix[2]),
    .apr_fm_adr_10_h       (ix[3]),
    .con_fm_write_00to17_l (wl_n),
    .con_fm_write_18to35_l (wr_n),
    .con_fm_check_en_h     (ck),
    .edp_fm_parity_00to05_h(p[0]),
    .edp_fm_parity_06to11_h(p[1]),
    .edp_fm_parity_12to17_h(p[2]),
    .edp_fm_parity_18to23_h(p[3]),
    .edp_fm_parity_24to29_h(p[4]),
    .edp_fm_parity_30to35_h(p[5]),
    .apr_fm_par_clr_h      (clr),
    .apr_fm_inject_h       (inj),
    .apr_fm_par_err_h      (err),
    .apr_fm_par_overrun_h  (ovr),
    .apr_fm_err_adr_h      (eadr),
    .apr_fm_err_half_h     (ehalf)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: per-half store, one pending check result, error record.
  bit       m_val_l[128], m_val_r[128], m_par_l[128], m_par_r[128];
  bit       m_err, m_ovr;
  bit [6:0] m_adr;
  bit [1:0] m_half;
  bit [6:0] pend_idx;
  bit [1:0] pend_m;

  function automatic void model_reset();
    for (int i = 0; i < 128; i++) begin
      m_val_l[i] = 0; m_val_r[i] = 0;
    end
    m_err = 0; m_ovr = 0; m_adr = 0; m_half = 0;
    pend_idx = 0; pend_m = 0;
  endfunction

  // Applies the spec's rules for one rising edge using the inputs seen at it.
  function automatic void model_edge();
    bit plm, prm, wl, wr, ip;
    plm = ((p[0] + p[1] + p[2]) % 2) == 0;
    prm = ((p[3] + p[4] + p[5]) % 2) == 0;
    wl  = !wl_n;
    wr  = !wr_n;
    ip  = INJ_EN && inj;
    // result of the check sampled one edge earlier
    if (pend_m != 0) begin
      if (!m_err || clr) begin
        m_err = 1; m_ovr = 0; m_adr = pend_idx; m_half = pend_m;
      end else m_ovr = 1;
    end else if (clr) begin
      m_err = 0; m_ovr = 0; m_adr = 0; m_half = 0;
    end
    pend_idx = ix;
    pend_m   = 0;
    if (ck) begin
      pend_m[1] = m_val_l[ix] && !wl && (m_par_l[ix] != plm);
      pend_m[0] = m_val_r[ix] && !wr && (m_par_r[ix] != prm);
    end
    if (wl) begin m_val_l[ix] = 1; m_par_l[ix] = plm ^ ip; end
    if (wr) begin m_val_r[ix] = 1; m_par_r[ix] = prm ^ ip; end
  endfunction

  task automatic compare_all(input string ph);
    check({ph, "_err"},  err,   m_err);
    check({ph, "_ovr"},  ovr,   m_ovr);
    check({ph, "_adr"},  eadr,  m_adr);
    check({ph, "_half"}, ehalf, m_half);
  endtask

  task automatic step(input logic [6:0] a, input bit wl, input bit wr, input bit c,
                      input logic [5:0] bits, input bit cl, input bit in);
    ix = a; wl_n = !wl; wr_n = !wr; ck = c; p = bits; clr = cl; inj = in;
    @(posedge clk);
    model_edge();
    #1;
    compare_all("step");
  endtask

  task automatic idle(input bit cl);
    step(7'h00, 0, 0, 0, 6'b000000, cl, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    compare_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Good data: pl=0, pr=1. Bad data inverts both halves' parity.
  localparam logic [5:0] GOOD   = 6'b110_001;
  localparam logic [5:0] BAD_R  = 6'b111_001;
  localparam logic [5:0] BAD_LR = 6'b001_000;

  initial begin
    model_reset();
    #12;
    check("reset_err",  err,   1'b0);
    check("reset_ovr",  ovr,   1'b0);
    check("reset_adr",  eadr,  7'h00);
    check("reset_half", ehalf, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // unwritten entry never flags
    step(7'h25, 0, 0, 1, 6'($urandom), 0, 0);
    idle(0);
    check("unwritten_err", err, 1'b0);

    // write both halves, good check, then right-half mismatch
    step(7'h13, 1, 1, 0, GOOD, 0, 0);
    step(7'h13, 0, 0, 1, GOOD, 0, 0);
    idle(0);
    check("good_err", err, 1'b0);
    step(7'h13, 0, 0, 1, BAD_R, 0, 0);
    check("latency_err", err, 1'b0);
    idle(0);
    check("mis_err",  err,   1'b1);
    check("mis_adr",  eadr,  7'h13);
    check("mis_half", ehalf, 2'b01);

    // overrun keeps first address
    step(7'h40, 1, 1, 0, GOOD, 0, 0);
    step(7'h40, 0, 0, 1, BAD_R, 0, 0);
    idle(0);
    check("ovr_ovr", ovr,  1'b1);
    check("ovr_adr", eadr, 7'h13);

    // clear together with a new mismatch: mismatch wins
    step(7'h07, 1, 1, 0, GOOD, 0, 0);
    step(7'h07, 0, 0, 1, BAD_LR, 0, 0);
    idle(1);
    check("clrmis_err",  err,   1'b1);
    check("clrmis_adr",  eadr,  7'h07);
    check("clrmis_ovr",  ovr,   1'b0);
    check("clrmis_half", ehalf, 2'b11);
    idle(1);
    check("clr_err", err,  1'b0);
    check("clr_adr", eadr, 7'h00);

    // same-cycle left write + check: only right half compared
    step(7'h22, 1, 1, 0, GOOD, 0, 0);
    step(7'h22, 1, 0, 1, BAD_LR, 0, 0);
    idle(0);
    check("wrchk_err",  err,   1'b1);
    check("wrchk_half", ehalf, 2'b01);
    idle(1);
    step(7'h33, 1, 0, 1, BAD_LR, 0, 0);
    idle(0);
    check("wrchk_inv_err", err, 1'b0);

    // parity inject
    step(7'h7F, 1, 1, 0, GOOD, 0, 1);
    step(7'h7F, 0, 0, 1, GOOD, 0, 0);
    idle(0);
    check("inj_err",  err,   INJ_EN ? 32'd1 : 32'd0);
    check("inj_half", ehalf, INJ_EN ? 32'd3 : 32'd0);
    idle(1);

    // reset while a failing check is pending
    step(7'h13, 0, 0, 1, BAD_LR, 0, 0);
    do_reset();
    idle(0);
    check("rstpend_err", err, 1'b0);
    for (int i = 0; i < 128; i++) step(7'(i), 0, 0, 1, 6'($urandom), 0, 0);
    idle(0);
    check("rst_invalid_err", err, 1'b0);
    check("rst_invalid_ovr", ovr, 1'b0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [6:0] a;
      a = 7'($urandom) & 7'h47;
      if (n % 700 == 350) do_reset();
      step(a, ($urandom % 3) == 0, ($urandom % 3) == 0, $urandom % 2,
           6'($urandom), ($urandom % 12) == 0, ($urandom % 6) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
